// File: rtl/lemming_pkg.sv
// rtl/lemming_pkg.sv - shared types, counter widths and helpers for the lemming tracker
package lemming_pkg;

    localparam int CNT8_W  = 8;
    localparam int CNT16_W = 16;

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_FALLING = 2'd1,
        ST_DEAD    = 2'd2
    } state_t;

    // True when two or more bits of the behaviour vector are set.
    function automatic logic multi_hot(input logic [4:0] v);
        return (v & (v - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, with synchronous clear
//
// Ports:
//   clk, areset_n : clock, asynchronous active-low reset (count -> 0)
//   clr           : synchronous clear, wins over inc
//   inc           : count up by one unless already at all-ones
//   count         : current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lemming_tracker.sv
// rtl/lemming_tracker.sv - tracks position, walk statistics and fall/death status of one lemming
//
// Ports:
//   clk, areset_n          : clock, asynchronous active-low reset
//   walk_left, walk_right,
//   aah, digging, jumping  : behaviour flags from the upstream lemming FSM (expected one-hot)
//   clr_stats              : synchronous clear of steps, fall_last and illegal
//   pos_x                  : horizontal position, 0..X_MAX
//   steps                  : saturating count of cycles in which pos_x moved
//   fall_cur, fall_last    : length of the fall in progress / of the last landed fall
//   at_wall_l, at_wall_r   : pos_x is at the left / right edge
//   dead                   : sticky, lemming has stopped with no behaviour active
//   splat_evt              : one-cycle pulse when a too-long fall ends in death
//   illegal                : sticky, more than one behaviour flag was seen at once
module lemming_tracker
    import lemming_pkg::*;
#(
    parameter int XW         = 8,
    parameter int X_MAX      = 159,
    parameter int X_INIT     = 0,
    parameter int FALL_LIMIT = 20
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               walk_left,
    input  logic               walk_right,
    input  logic               aah,
    input  logic               digging,
    input  logic               jumping,
    input  logic               clr_stats,
    output logic [XW-1:0]      pos_x,
    output logic [CNT16_W-1:0] steps,
    output logic [CNT8_W-1:0]  fall_cur,
    output logic [CNT8_W-1:0]  fall_last,
    output logic               at_wall_l,
    output logic               at_wall_r,
    output logic               dead,
    output logic               splat_evt,
    output logic               illegal
);

    localparam logic [XW-1:0]     XMAX_V      = XW'(X_MAX);
    localparam logic [XW-1:0]     XINIT_V     = XW'(X_INIT);
    localparam logic [CNT8_W-1:0] FALL_LIM_V  = CNT8_W'(FALL_LIMIT);
    localparam logic              WALL_L_INIT = (X_INIT == 0);
    localparam logic              WALL_R_INIT = (X_INIT == X_MAX);

    state_t        state;
    state_t        state_next;
    logic          dir;
    logic [4:0]    beh;
    logic          none;
    logic          live;
    logic          legal;
    logic          falling;
    logic          go_left;
    logic          go_right;
    logic [XW-1:0] pos_next;
    logic          moved;
    logic          land;

    assign beh     = {walk_left, walk_right, aah, digging, jumping};
    assign none    = (beh == 5'd0);
    assign live    = (state != ST_DEAD);
    // A multi-hot cycle freezes everything except the illegal flag.
    assign legal   = live && !multi_hot(beh);
    assign falling = (state == ST_FALLING);
    assign land    = legal && falling && !aah && !none;

    // Jumping carries the lemming along its last walking direction.
    assign go_left  = legal && (walk_left  || (jumping && !dir));
    assign go_right = legal && (walk_right || (jumping &&  dir));

    always_comb begin
        pos_next = pos_x;
        if (go_left && (pos_x != '0)) begin
            pos_next = pos_x - XW'(1);
        end else if (go_right && (pos_x != XMAX_V)) begin
            pos_next = pos_x + XW'(1);
        end
    end

    assign moved = (pos_next != pos_x);

    always_comb begin
        state_next = state;
        if (legal) begin
            case (state)
                ST_ACTIVE: begin
                    if (none) state_next = ST_DEAD;
                    else if (aah) state_next = ST_FALLING;
                end
                ST_FALLING: begin
                    if (none) state_next = ST_DEAD;
                    else if (!aah) state_next = ST_ACTIVE;
                end
                default: state_next = state;
            endcase
        end
    end

    sat_counter #(.W(CNT16_W)) u_steps (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (clr_stats),
        .inc      (moved),
        .count    (steps)
    );

    // fall_cur is always 0 in ACTIVE, so the first aah increment loads 1.
    sat_counter #(.W(CNT8_W)) u_fall (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (land),
        .inc      (legal && aah),
        .count    (fall_cur)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= ST_ACTIVE;
            pos_x     <= XINIT_V;
            dir       <= 1'b0;
            fall_last <= '0;
            illegal   <= 1'b0;
            splat_evt <= 1'b0;
            at_wall_l <= WALL_L_INIT;
            at_wall_r <= WALL_R_INIT;
        end else begin
            state     <= state_next;
            pos_x     <= pos_next;
            at_wall_l <= (pos_next == '0);
            at_wall_r <= (pos_next == XMAX_V);
            splat_evt <= legal && falling && none && (fall_cur > FALL_LIM_V);
            if (legal && walk_left) begin
                dir <= 1'b0;
            end else if (legal && walk_right) begin
                dir <= 1'b1;
            end
            if (clr_stats) begin
                fall_last <= '0;
            end else if (land) begin
                fall_last <= fall_cur;
            end
            if (clr_stats) begin
                illegal <= 1'b0;
            end else if (live && !legal) begin
                illegal <= 1'b1;
            end
        end
    end

    assign dead = (state == ST_DEAD);

endmodule

// File: tb/tb_lemming_tracker.sv
// tb/tb_lemming_tracker.sv - scoreboard bench for lemming_tracker against a behavioural model
module tb_lemming_tracker;

    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    logic        walk_left = 1'b0, walk_right = 1'b0, aah = 1'b0, digging = 1'b0, jumping = 1'b0;
    logic        clr_stats = 1'b0;
    logic [7:0]  pos_x;
    logic [15:0] steps;
    logic [7:0]  fall_cur, fall_last;
    logic        at_wall_l, at_wall_r, dead, splat_evt, illegal;

    localparam logic [4:0] B_WL = 5'b10000, B_WR = 5'b01000, B_AAH = 5'b00100,
                           B_DIG = 5'b00010, B_JMP = 5'b00001, B_NONE = 5'b00000;

    lemming_tracker dut (
        .clk(clk), .areset_n(areset_n),
        .walk_left(walk_left), .walk_right(walk_right), .aah(aah),
        .digging(digging), .jumping(jumping), .clr_stats(clr_stats),
        .pos_x(pos_x), .steps(steps), .fall_cur(fall_cur), .fall_last(fall_last),
        .at_wall_l(at_wall_l), .at_wall_r(at_wall_r), .dead(dead),
        .splat_evt(splat_evt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos, stp, fc, fl;
        bit wl, wr, dd, splat, ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a lemming described by its position, heading and flags.
    int m_pos, m_steps, m_fc, m_fl;
    bit m_right, m_falling, m_dead, m_ill, m_splat;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.pos = m_pos; e.stp = m_steps; e.fc = m_fc; e.fl = m_fl;
        e.wl = (m_pos == 0); e.wr = (m_pos == 159);
        e.dd = m_dead; e.splat = m_splat; e.ill = m_ill;
        return e;
    endfunction

    task automatic check_all(input exp_t e, input string tag);
        cmp({tag, " pos_x"},     int'(pos_x),     e.pos);
        cmp({tag, " steps"},     int'(steps),     e.stp);
        cmp({tag, " fall_cur"},  int'(fall_cur),  e.fc);
        cmp({tag, " fall_last"}, int'(fall_last), e.fl);
        cmp({tag, " at_wall_l"}, int'(at_wall_l), int'(e.wl));
        cmp({tag, " at_wall_r"}, int'(at_wall_r), int'(e.wr));
        cmp({tag, " dead"},      int'(dead),      int'(e.dd));
        cmp({tag, " splat_evt"}, int'(splat_evt), int'(e.splat));
        cmp({tag, " illegal"},   int'(illegal),   int'(e.ill));
    endtask

    task automatic model_reset();
        m_pos = 0; m_steps = 0; m_fc = 0; m_fl = 0;
        m_right = 0; m_falling = 0; m_dead = 0; m_ill = 0; m_splat = 0;
    endtask

    task automatic model_step(input logic [4:0] b, input bit clr);
        int n;
        int target;
        n = $countones(b);
        m_splat = 0;
        if (!m_dead) begin
            if (n > 1) begin
                m_ill = 1;
            end else begin
                if (b == B_WL) m_right = 0;
                if (b == B_WR) m_right = 1;
                target = m_pos;
                if (b == B_WL || (b == B_JMP && !m_right)) target = m_pos - 1;
                if (b == B_WR || (b == B_JMP &&  m_right)) target = m_pos + 1;
                if (target >= 0 && target <= 159 && target != m_pos) begin
                    m_pos = target;
                    if (m_steps < 65535) m_steps++;
                end
                if (n == 0) begin
                    if (m_falling && m_fc > 20) m_splat = 1;
                    m_dead = 1;
                    m_falling = 0;
                end else if (b == B_AAH) begin
                    if (m_fc < 255) m_fc++;
                    m_falling = 1;
                end else if (m_falling) begin
                    m_fl = m_fc;
                    m_fc = 0;
                    m_falling = 0;
                end
            end
        end
        if (clr) begin
            m_steps = 0; m_fl = 0; m_ill = 0;
        end
    endtask

    task automatic step(input logic [4:0] b, input bit clr);
        @(negedge clk);
        areset_n = 1'b1;
        {walk_left, walk_right, aah, digging, jumping} = b;
        clr_stats = clr;
        model_step(b, clr);
        q.push_back(snap());
    endtask

    task automatic steps_n(input logic [4:0] b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    // Asserts reset between edges and checks that outputs respond without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        areset_n = 1'b0;
        {walk_left, walk_right, aah, digging, jumping} = 5'b0;
        clr_stats = 1'b0;
        #1;
        model_reset();
        check_all(snap(), "reset");
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_all(e, "cycle");
        end
    end

    initial begin
        logic [4:0] b;
        int r, i, j, len;
        bit clr;

        model_reset();
        do_reset();

        // Left wall from position 0.
        steps_n(B_WL, 3);

        // Walk right, then jump along the heading, then run into the right wall.
        steps_n(B_WR, 10);
        steps_n(B_JMP, 2);
        steps_n(B_WR, 147);
        steps_n(B_WR, 3);
        steps_n(B_JMP, 2);

        // Short fall and landing.
        steps_n(B_AAH, 5);
        step(B_WL, 1'b0);

        // Long fall ending in a splat, then frozen while dead.
        steps_n(B_AAH, 25);
        step(B_NONE, 1'b0);
        steps_n(B_WR, 10);

        // Illegal combination, then clear statistics.
        do_reset();
        steps_n(B_WR, 3);
        step(B_WL | B_AAH, 1'b0);
        step(B_DIG, 1'b1);

        // Fall exactly at the limit does not splat.
        steps_n(B_AAH, 20);
        step(B_NONE, 1'b0);
        do_reset();

        // Fall counter saturation.
        step(B_DIG, 1'b0);
        steps_n(B_AAH, 260);
        step(B_WL, 1'b0);

        // Reset mid-fall.
        steps_n(B_AAH, 7);
        do_reset();
        @(posedge clk);
        #2;
        cmp("hold_reset splat_evt", int'(splat_evt), 0);
        cmp("hold_reset fall_cur", int'(fall_cur), 0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            if (m_dead) begin
                if ($urandom_range(0, 7) == 0) do_reset();
                else step(5'($urandom_range(0, 31)), 1'b0);
                continue;
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            r = $urandom_range(0, 99);
            clr = ($urandom_range(0, 24) == 0);
            if (r < 3) begin
                len = $urandom_range(10, 30);
                steps_n(B_AAH, len);
                continue;
            end else if (r < 7) begin
                b = B_NONE;
            end else if (r < 13) begin
                i = $urandom_range(0, 4);
                j = (i + $urandom_range(1, 4)) % 5;
                b = (5'd1 << i) | (5'd1 << j);
            end else begin
                b = 5'd1 << $urandom_range(0, 4);
            end
            step(b, clr);
        end

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cmp("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
